ex_muldiv_seq: RTL and testbench
================================

// Module: ex_muldiv_seq
// PURPOSE
//  Iterative RV32M multiply/divide sequencer beside the execute stage. Accepts one op from EX,
//  runs a radix-2 shift-add / restoring-divide loop on a private adder, and stalls the pipeline
//  while busy. Returns result + rd for writeback with a one-cycle done pulse. Honors pipeline flush.
// PARAMETERS
//  XLEN   32  operand/result width
//  CNT_W  6   iteration counter width, >= clog2(XLEN)+1
// PORTS
//  clk      in   1     single clock, rising edge
//  rst      in   1     asynchronous, active-high reset
//  start    in   1     EX presents an M-ext op this cycle
//  func3    in   3     M op: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  rs1      in   XLEN  operand A (dividend / multiplicand)
//  rs2      in   XLEN  operand B (divisor / multiplier)
//  rd_in    in   5     destination register
//  flush    in   1     kill in-flight op (branch/trap)
//  stall    out  1     hold IF/ID/EX; combinational = busy | (start & state==IDLE & !flush)
//  busy     out  1     registered; op in flight
//  done     out  1     one-cycle pulse, result/rd_out/reg_wr valid
//  result   out  XLEN  selected product half, quotient or remainder
//  rd_out   out  5     captured rd_in
//  reg_wr   out  1     = done & (rd_out != 0)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0.
//  FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: start & !flush at edge -> capture func3, rd, |rs1|,|rs2| per signedness, signs; -> CALC.
//   CALC: XLEN cycles, counter 0..XLEN-1. MUL: 2*XLEN acc, add multiplicand if LSB, shift right.
//         DIV: shift rem:quot left, trial subtract divisor, keep if non-negative, quot bit = !borrow.
//   FIX: apply sign correction; MUL/MULH*: low vs high half; DIV quot sign = sA^sB, REM sign = sA.
//   DONE: done=1 one cycle, result registered; -> IDLE. busy=1 from CALC through DONE inclusive.
//  Latency: done asserted XLEN+2 edges after start-sampling edge (34 for XLEN=32). Throughput 1/(XLEN+3).
//  MULHSU: rs1 signed, rs2 unsigned. MULHU/DIVU/REMU: both unsigned.
//  Div-by-zero: quotient = all ones, remainder = rs1 (unmodified). Signed overflow
//   (0x8000_0000 / -1): quotient = 0x8000_0000, remainder = 0. Both flagged at capture, loop still runs.
//  start while busy or in DONE: ignored (EX is stalled, so it re-presents the op).
//  flush in CALC/FIX: -> IDLE next edge, busy=0, no done. flush in DONE: done still pulses (already
//   committed in the writeback order). flush & start in IDLE: flush wins, nothing captured.
//  result holds last value until next done; outputs only meaningful when done=1.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: div-by-zero, signed overflow, or either operand == 0 skip CALC;
//   IDLE -> FIX -> DONE, done 2 edges after start. Undefined: all ops take the full XLEN+2 latency.
//   Results identical either way.
// STRUCTURE
//  muldiv_pkg: func3 op localparams (OP_MUL..OP_REMU), state encoding (ST_IDLE/CALC/FIX/DONE),
//   helper functions is_div(op), op_signed_a(op), op_signed_b(op).
//  One sub-module: muldiv_step (combinational single iteration: add/sub on XLEN+1 bits, returns
//   next acc and quotient bit); the sequencer owns all registers and the FSM.
// TESTING
//  MUL 7*6: start 1 cycle -> stall 1 through done; done at edge 34, result=42, reg_wr=1 with rd=5.
//  DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; REMU 7/2 -> 1.
//  DIVU 0x1234/0 -> 0xFFFF_FFFF; REM 0x1234/0 -> 0x1234; DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000, REM -> 0.
//  MULHU 0xFFFF_FFFF*0xFFFF_FFFF -> 0xFFFF_FFFE; MULH same operands -> 0; MULHSU -1*2 -> 0xFFFF_FFFF.
//  flush at CALC cycle 10 -> busy=0 next edge, no done ever; new start next cycle completes normally.
//  rst asserted mid-CALC -> all outputs 0 immediately (async); rd_in=0 op -> done=1, reg_wr=0;
//   with MULDIV_EARLY_OUT_EN, DIV x/0 -> done 2 edges after start.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// func3 op codes, FSM state encoding and op-decode helpers.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Divide/remainder ops share the upper func3 half
   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   // Operand A is treated as two's complement
   function automatic logic op_signed_a(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   // Operand B is treated as two's complement
   function automatic logic op_signed_b(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the shared XLEN+1 bit adder.
// Multiply: acc = {hi, multiplier}; add multiplicand to hi when LSB set, shift right.
// Divide:   acc = {rem, quot}; shift left, trial-subtract divisor, keep if no borrow.
//           The returned acc has LSB 0; the quotient bit is returned separately.
module muldiv_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic                i_div,
   input  logic [2*XLEN-1:0]   i_acc,
   input  logic [XLEN-1:0]     i_opb,
   output logic [2*XLEN-1:0]   o_acc,
   output logic                o_qbit
);

   logic [XLEN:0]   w_opa;
   logic [XLEN:0]   w_addend;
   logic [XLEN+1:0] w_sum;

   // Single add/sub with an extra top bit to expose carry/borrow
   always_comb begin
      w_opa    = i_div ? i_acc[2*XLEN-1:XLEN-1] : {1'b0, i_acc[2*XLEN-1:XLEN]};
      w_addend = (i_div || i_acc[0]) ? {1'b0, i_opb} : '0;
      w_sum    = i_div ? ({1'b0, w_opa} - {1'b0, w_addend})
                       : ({1'b0, w_opa} + {1'b0, w_addend});
      o_qbit   = i_div & ~w_sum[XLEN+1];
      if (i_div) begin
         o_acc = {(o_qbit ? w_sum[XLEN-1:0] : w_opa[XLEN-1:0]), i_acc[XLEN-2:0], 1'b0};
      end else begin
         o_acc = {w_sum[XLEN:0], i_acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer beside EX. Captures one op, runs
// XLEN radix-2 iterations, sign-fixes, then pulses done with result/rd.
// Optional feature macro: MULDIV_EARLY_OUT_EN (zero operands, divide-by-zero
// and signed overflow bypass the iteration loop; results unchanged).
module ex_muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            reg_wr
);

   localparam int unsigned     DW       = 2 * XLEN;
   localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(XLEN - 1);

   state_t            r_state, w_next;
   logic [2:0]        r_op;
   logic [4:0]        r_rd;
   logic              r_sa, r_sb, r_dbz, r_ovf, r_zero;
   logic [XLEN-1:0]   r_rs1, r_opb;
   logic [DW-1:0]     r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_busy, r_done, r_reg_wr;
   logic [XLEN-1:0]   r_result;
   logic [4:0]        r_rd_out;

   logic              w_capture, w_iter, w_fix, w_commit;
   logic              w_sa, w_sb, w_dbz, w_ovf, w_zero;
   logic [XLEN-1:0]   w_abs_a, w_abs_b;
   logic [DW-1:0]     w_step_acc;
   logic              w_step_qbit;
   logic [DW-1:0]     w_prod;
   logic [XLEN-1:0]   w_quot, w_rem, w_fix_res;

   // Operand conditioning at capture: magnitudes, signs and special cases
   always_comb begin
      w_sa    = op_signed_a(func3) & rs1[XLEN-1];
      w_sb    = op_signed_b(func3) & rs2[XLEN-1];
      w_abs_a = w_sa ? (~rs1 + XLEN'(1)) : rs1;
      w_abs_b = w_sb ? (~rs2 + XLEN'(1)) : rs2;
      w_dbz   = is_div(func3) & (rs2 == '0);
      w_ovf   = is_div(func3) & op_signed_a(func3) & (rs1 == XMIN) & (rs2 == '1);
      w_zero  = (rs1 == '0) | (rs2 == '0);
   end

   muldiv_step #(.XLEN(XLEN)) u_step (
      .i_div  (is_div(r_op)),
      .i_acc  (r_acc),
      .i_opb  (r_opb),
      .o_acc  (w_step_acc),
      .o_qbit (w_step_qbit)
   );

   // Sign correction and result-half selection for the FIX cycle
   always_comb begin
      w_quot = r_acc[XLEN-1:0];
      w_rem  = r_acc[DW-1:XLEN];
      if (r_zero) begin
         w_prod = '0;
      end else if (r_sa ^ r_sb) begin
         w_prod = ~r_acc + DW'(1);
      end else begin
         w_prod = r_acc;
      end
      case (r_op)
         OP_MUL:                       w_fix_res = w_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[DW-1:XLEN];
         OP_DIV, OP_DIVU: begin
            if (r_dbz)              w_fix_res = '1;
            else if (r_ovf)         w_fix_res = XMIN;
            else if (r_sa ^ r_sb)   w_fix_res = ~w_quot + XLEN'(1);
            else                    w_fix_res = w_quot;
         end
         default: begin
            if (r_dbz)              w_fix_res = r_rs1;
            else if (r_ovf)         w_fix_res = '0;
            else if (r_sa)          w_fix_res = ~w_rem + XLEN'(1);
            else                    w_fix_res = w_rem;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next-state logic; flush aborts CALC/FIX but not a committed DONE
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start && !flush) begin
`ifdef MULDIV_EARLY_OUT_EN
               w_next = (w_dbz || w_ovf || w_zero) ? ST_FIX : ST_CALC;
`else
               w_next = ST_CALC;
`endif
            end
         end
         ST_CALC: begin
            if (flush)                w_next = ST_IDLE;
            else if (r_cnt == LAST_IT) w_next = ST_FIX;
         end
         ST_FIX:  w_next = flush ? ST_IDLE : ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // FSM output decode: datapath enables per state
   always_comb begin
      w_capture = 1'b0;
      w_iter    = 1'b0;
      w_fix     = 1'b0;
      w_commit  = 1'b0;
      case (r_state)
         ST_IDLE: w_capture = start & ~flush;
         ST_CALC: w_iter    = ~flush;
         ST_FIX:  w_fix     = ~flush;
         ST_DONE: w_commit  = 1'b1;
         default: ;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op     <= '0;
         r_rd     <= '0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_dbz    <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
         r_rs1    <= '0;
         r_opb    <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_reg_wr <= 1'b0;
         r_result <= '0;
         r_rd_out <= '0;
      end else begin
         r_busy   <= (w_next != ST_IDLE);
         r_done   <= w_commit;
         r_reg_wr <= w_commit & (r_rd != '0);
         if (w_capture) begin
            r_op   <= func3;
            r_rd   <= rd_in;
            r_sa   <= w_sa;
            r_sb   <= w_sb;
            r_dbz  <= w_dbz;
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
            r_rs1  <= rs1;
            r_opb  <= is_div(func3) ? w_abs_b : w_abs_a;
            r_acc  <= {{XLEN{1'b0}}, (is_div(func3) ? w_abs_a : w_abs_b)};
            r_cnt  <= '0;
         end
         if (w_iter) begin
            r_acc <= {w_step_acc[DW-1:1], w_step_acc[0] | w_step_qbit};
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_fix) begin
            r_acc[XLEN-1:0] <= w_fix_res;
         end
         if (w_commit) begin
            r_result <= r_acc[XLEN-1:0];
            r_rd_out <= r_rd;
         end
      end
   end

   assign stall  = r_busy | (start & (r_state == ST_IDLE) & ~flush);
   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign rd_out = r_rd_out;
   assign reg_wr = r_reg_wr;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed self-checking bench for ex_muldiv_seq (optionally built with
// MULDIV_EARLY_OUT_EN, which shortens latency for the flagged vectors).
module tb_ex_muldiv_seq;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EO_EN = 1'b1;
`else
   localparam bit EO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  func3;
   logic [31:0] rs1, rs2;
   logic [4:0]  rd_in;
   logic        flush;
   logic        stall, busy, done, reg_wr;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ex_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .func3  (func3),
      .rs1    (rs1),
      .rs2    (rs2),
      .rd_in  (rd_in),
      .flush  (flush),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .result (result),
      .rd_out (rd_out),
      .reg_wr (reg_wr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic watch_no_done(input string tag, input int n);
      int c = 0;
      repeat (n) begin
         @(posedge clk); #1;
         if (done === 1'b1) c++;
      end
      chk(tag, 32'(c), 32'd0);
   endtask

   // Issue one op for a single cycle and check latency, result and writeback
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input bit eo);
      int lat;
      int exp_lat;
      exp_lat = (EO_EN && eo) ? 2 : 34;
      @(negedge clk);
      start = 1'b1; func3 = f; rs1 = a; rs2 = b; rd_in = rd;
      #1 chk({tag, "_stall_req"}, 32'(stall), 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_stall_busy"}, 32'(stall), 32'd1);
      lat = 0;
      while (done !== 1'b1 && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_res"}, result, exp);
      chk({tag, "_rd"}, 32'(rd_out), 32'(rd));
      chk({tag, "_regwr"}, 32'(reg_wr), 32'(rd != 5'd0));
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; func3 = '0; rs1 = '0; rs2 = '0; rd_in = '0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",   32'(busy),   32'd0);
      chk("rst_done",   32'(done),   32'd0);
      chk("rst_result", result,      32'd0);
      chk("rst_rd",     32'(rd_out), 32'd0);
      chk("rst_regwr",  32'(reg_wr), 32'd0);
      chk("rst_stall",  32'(stall),  32'd0);
      @(negedge clk) rst = 1'b0;

      run_op("mul_7x6",   3'd0, 32'd7,          32'd6,          5'd5,  32'd42,         1'b0);
      run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  1'b0);
      run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFF,  1'b0);
      run_op("remu_7_2",  3'd7, 32'd7,          32'd2,          5'd4,  32'd1,          1'b0);
      run_op("div_7_m2",  3'd4, 32'd7,          32'hFFFF_FFFE,  5'd6,  32'hFFFF_FFFD,  1'b0);
      run_op("rem_7_m2",  3'd6, 32'd7,          32'hFFFF_FFFE,  5'd6,  32'd1,          1'b0);
      run_op("div_100_7", 3'd4, 32'd100,        32'd7,          5'd8,  32'd14,         1'b0);
      run_op("rem_100_7", 3'd6, 32'd100,        32'd7,          5'd8,  32'd2,          1'b0);
      run_op("divu_big",  3'd5, 32'hFFFF_FFFF,  32'h10,         5'd9,  32'h0FFF_FFFF,  1'b0);
      run_op("divu_dbz",  3'd5, 32'h1234,       32'd0,          5'd10, 32'hFFFF_FFFF,  1'b1);
      run_op("rem_dbz",   3'd6, 32'h1234,       32'd0,          5'd10, 32'h1234,       1'b1);
      run_op("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000,  1'b1);
      run_op("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          1'b1);
      run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd12, 32'hFFFF_FFFE,  1'b0);
      run_op("mulh_m1",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd12, 32'd0,          1'b0);
      run_op("mulhsu",    3'd2, 32'hFFFF_FFFF,  32'd2,          5'd13, 32'hFFFF_FFFF,  1'b0);
      run_op("mul_m3x5",  3'd0, 32'hFFFF_FFFD,  32'd5,          5'd14, 32'hFFFF_FFF1,  1'b0);
      run_op("mulh_m3x5", 3'd1, 32'hFFFF_FFFD,  32'd5,          5'd14, 32'hFFFF_FFFF,  1'b0);
      run_op("mulhu_sh",  3'd3, 32'h8000_0000,  32'd4,          5'd15, 32'd2,          1'b0);
      run_op("mul_zero",  3'd0, 32'd0,          32'd5,          5'd7,  32'd0,          1'b1);
      run_op("mul_rd0",   3'd0, 32'd3,          32'd4,          5'd0,  32'd12,         1'b0);

      // flush during CALC: aborts, no done, next op runs normally
      @(negedge clk);
      start = 1'b1; func3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; rd_in = 5'd2;
      @(posedge clk); #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_done", 32'(done), 32'd0);
      watch_no_done("flush_nodone", 40);
      run_op("after_flush", 3'd0, 32'd11, 32'd3, 5'd1, 32'd33, 1'b0);

      // flush with start in IDLE: flush wins
      @(negedge clk);
      start = 1'b1; flush = 1'b1; func3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2; rd_in = 5'd2;
      #1 chk("flush_start_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flush_start_busy", 32'(busy), 32'd0);
      watch_no_done("flush_start_nodone", 40);

      // flush while in DONE: done still pulses
      @(negedge clk);
      start = 1'b1; func3 = 3'd0; rs1 = 32'd5; rs2 = 32'd5; rd_in = 5'd3;
      @(posedge clk); #1 start = 1'b0;
      repeat (33) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_done_pulse", 32'(done), 32'd1);
      chk("flush_done_res", result, 32'd25);

      // async reset mid-CALC clears outputs immediately
      @(negedge clk);
      start = 1'b1; func3 = 3'd0; rs1 = 32'd6; rs2 = 32'd6; rd_in = 5'd4;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy",   32'(busy),   32'd0);
      chk("arst_done",   32'(done),   32'd0);
      chk("arst_result", result,      32'd0);
      chk("arst_rd",     32'(rd_out), 32'd0);
      chk("arst_regwr",  32'(reg_wr), 32'd0);
      chk("arst_stall",  32'(stall),  32'd0);
      @(negedge clk) rst = 1'b0;
      watch_no_done("arst_nodone", 40);
      run_op("after_rst", 3'd7, 32'd100, 32'd7, 5'd31, 32'd2, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
